audio_frame_sequencer: RTL and testbench

//  Sequences one stereo frame at a time between the Audio_Controller FIFOs and the effects datapath.
//  Per frame: pops a sample pair from the ADC FIFO, issues it to the effect chain with a valid/ready

---
 rtl/audio_frame_sequencer_if.sv | 34 +++
 rtl/audio_frame_sequencer.sv | 122 ++++++++++++
 tb/tb_audio_frame_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_sequencer_if.sv
// rtl/audio_frame_sequencer_if.sv - ADC FIFO, DAC FIFO and effect-chain signal bundle for the frame sequencer
interface audio_frame_sequencer_if #(
   parameter int DW = 32
);
   logic          audio_in_available;
   logic          audio_out_allowed;
   logic          read_audio_in;
   logic          write_audio_out;
   logic [DW-1:0] left_in;
   logic [DW-1:0] right_in;
   logic [DW-1:0] left_out;
   logic [DW-1:0] right_out;
   logic          fx_valid;
   logic          fx_ready;
   logic [DW-1:0] fx_L;
   logic [DW-1:0] fx_R;
   logic          fx_res_valid;
   logic [DW-1:0] fx_res_L;
   logic [DW-1:0] fx_res_R;

   modport master (
      input  audio_in_available, audio_out_allowed, left_in, right_in,
             fx_ready, fx_res_valid, fx_res_L, fx_res_R,
      output read_audio_in, write_audio_out, left_out, right_out,
             fx_valid, fx_L, fx_R
   );

   modport slave (
      output audio_in_available, audio_out_allowed, left_in, right_in,
             fx_ready, fx_res_valid, fx_res_L, fx_res_R,
      input  read_audio_in, write_audio_out, left_out, right_out,
             fx_valid, fx_L, fx_R
   );
endinterface

// File: rtl/audio_frame_sequencer.sv
// rtl/audio_frame_sequencer.sv - one stereo frame at a time, ADC FIFO -> effect chain -> DAC FIFO
// Optional FX_TIMEOUT_CNT_EN adds the saturating timeout_count output.
module audio_frame_sequencer #(
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 4096
`ifdef FX_TIMEOUT_CNT_EN
   ,
   parameter int TOCNT_W     = 16
`endif
) (
   input  logic                    CLOCK_50,
   input  logic                    reset_n,
   input  logic                    enable,
   audio_frame_sequencer_if.master bus,
   output logic                    busy,
   output logic                    timeout_flag
`ifdef FX_TIMEOUT_CNT_EN
   ,
   output logic [TOCNT_W-1:0]      timeout_count
`endif
);
   typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT_FX, WAIT_OUT, WRITE} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   state_t        state;
   logic          mode;
   logic [DW-1:0] raw_l;
   logic [DW-1:0] raw_r;
   logic [15:0]   wait_cnt;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         mode                <= 1'b0;
         raw_l               <= '0;
         raw_r               <= '0;
         wait_cnt            <= '0;
         busy                <= 1'b0;
         timeout_flag        <= 1'b0;
         bus.read_audio_in   <= 1'b0;
         bus.write_audio_out <= 1'b0;
         bus.left_out        <= '0;
         bus.right_out       <= '0;
         bus.fx_valid        <= 1'b0;
         bus.fx_L            <= '0;
         bus.fx_R            <= '0;
`ifdef FX_TIMEOUT_CNT_EN
         timeout_count       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.audio_in_available) begin
                  state             <= READ;
                  mode              <= enable;
                  bus.read_audio_in <= 1'b1;
                  busy              <= 1'b1;
               end
            end
            READ: begin
               bus.read_audio_in <= 1'b0;
               raw_l             <= bus.left_in;
               raw_r             <= bus.right_in;
               if (mode) begin
                  state        <= ISSUE;
                  bus.fx_valid <= 1'b1;
                  bus.fx_L     <= bus.left_in;
                  bus.fx_R     <= bus.right_in;
               end else begin
                  state         <= WAIT_OUT;
                  bus.left_out  <= bus.left_in;
                  bus.right_out <= bus.right_in;
               end
            end
            ISSUE: begin
               if (bus.fx_ready) begin
                  state        <= WAIT_FX;
                  bus.fx_valid <= 1'b0;
                  wait_cnt     <= '0;
               end
            end
            WAIT_FX: begin
               // A result arriving on the timeout cycle takes priority over substitution.
               if (bus.fx_res_valid) begin
                  state         <= WAIT_OUT;
                  bus.left_out  <= bus.fx_res_L;
                  bus.right_out <= bus.fx_res_R;
               end else if (wait_cnt == TO_LAST) begin
                  state         <= WAIT_OUT;
                  bus.left_out  <= raw_l;
                  bus.right_out <= raw_r;
                  timeout_flag  <= 1'b1;
`ifdef FX_TIMEOUT_CNT_EN
                  if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
`endif
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            WAIT_OUT: begin
               if (bus.audio_out_allowed) begin
                  state               <= WRITE;
                  bus.write_audio_out <= 1'b1;
               end
            end
            WRITE: begin
               state               <= IDLE;
               bus.write_audio_out <= 1'b0;
               busy                <= 1'b0;
            end
            default: begin
               state               <= IDLE;
               busy                <= 1'b0;
               bus.read_audio_in   <= 1'b0;
               bus.write_audio_out <= 1'b0;
               bus.fx_valid        <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_audio_frame_sequencer.sv
// tb/tb_audio_frame_sequencer.sv - scoreboard bench for audio_frame_sequencer
module tb_audio_frame_sequencer;
   localparam int DW = 32;
   localparam int TO = 8;

   logic CLOCK_50 = 1'b0;
   logic reset_n  = 1'b0;
   logic enable   = 1'b0;
   logic busy;
   logic timeout_flag;
`ifdef FX_TIMEOUT_CNT_EN
   logic [15:0] timeout_count;
`endif

   audio_frame_sequencer_if #(.DW(DW)) bus ();

   audio_frame_sequencer #(.DW(DW), .TIMEOUT_CYC(TO)) dut (
      .CLOCK_50     (CLOCK_50),
      .reset_n      (reset_n),
      .enable       (enable),
      .bus          (bus),
      .busy         (busy),
      .timeout_flag (timeout_flag)
`ifdef FX_TIMEOUT_CNT_EN
      ,
      .timeout_count(timeout_count)
`endif
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] sb[$];
   int          wr_cnt = 0;
   int          excl_viol = 0;
   int          seq_viol = 0;
   int          stab_viol = 0;
   bit          fxv_seen = 0;
   logic        prev_rd = 0, prev_wr = 0, prev_fxv = 0, prev_hs = 0;
   logic [DW-1:0] prev_fxl = '0, prev_fxr = '0;
   logic        exp_flag = 0;
   int          exp_tocnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard pop on every DAC push plus strobe/stability invariants.
   always @(negedge CLOCK_50) begin
      if (bus.write_audio_out) begin
         wr_cnt++;
         if (sb.size() == 0) check("sb_unexpected_write", 64'd1, 64'd0);
         else check("sb_data", {bus.left_out, bus.right_out}, sb.pop_front());
      end
      if (bus.read_audio_in && bus.write_audio_out) excl_viol++;
      if ((bus.read_audio_in && prev_rd) || (bus.write_audio_out && prev_wr)) seq_viol++;
      if (bus.fx_valid) fxv_seen = 1;
      if (bus.fx_valid && prev_fxv && !prev_hs && {bus.fx_L, bus.fx_R} != {prev_fxl, prev_fxr})
         stab_viol++;
      prev_rd  = bus.read_audio_in;
      prev_wr  = bus.write_audio_out;
      prev_fxv = bus.fx_valid;
      prev_hs  = bus.fx_valid && bus.fx_ready;
      prev_fxl = bus.fx_L;
      prev_fxr = bus.fx_R;
   end

   // res_d: WAIT_FX cycle index (0-based) carrying the result, -1 for none.
   task automatic run_frame(input string tag, input logic en, input logic [DW-1:0] l, r,
                            input int rdy_wait, input int res_d,
                            input logic [DW-1:0] rl, rr, input int hold_out);
      bit tmo;
      bit got_it;
      int kwo, exp_lat, lat, wr0;
      tmo = en && (res_d < 0 || res_d > TO - 1);
      if (en && !tmo) sb.push_back({rl, rr});
      else sb.push_back({l, r});
      wr0      = wr_cnt;
      fxv_seen = 0;
      enable   = en;
      bus.left_in  = l;
      bus.right_in = r;
      bus.fx_res_L = rl;
      bus.fx_res_R = rr;
      bus.fx_ready = (rdy_wait == 0);
      bus.audio_out_allowed  = (hold_out == 0);
      bus.audio_in_available = 1'b1;
      got_it = 0;
      for (int i = 0; i < 20 && !got_it; i++) begin
         @(negedge CLOCK_50);
         got_it = bus.read_audio_in;
      end
      check({tag, "_read"}, 64'(got_it), 64'd1);
      bus.audio_in_available = 1'b0;
      enable = ~en;
      if (en) begin
         got_it = 0;
         for (int i = 0; i < 20 && !got_it; i++) begin
            @(negedge CLOCK_50);
            got_it = bus.fx_valid;
         end
         check({tag, "_fx_offer"}, 64'(got_it), 64'd1);
         repeat (rdy_wait) @(negedge CLOCK_50);
         bus.fx_ready = 1'b1;
         check({tag, "_fx_data"}, {bus.fx_L, bus.fx_R}, {l, r});
         kwo = 2 + (tmo ? TO - 1 : res_d);
      end else begin
         kwo = 1;
      end
      exp_lat = kwo + 1 + hold_out;
      lat = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge CLOCK_50);
         if (bus.write_audio_out) lat = k;
         if (en && k == 1) check({tag, "_fx_drop"}, 64'(bus.fx_valid), 64'd0);
         bus.fx_res_valid = (en && res_d >= 0 && k == 1 + res_d);
         if (hold_out > 0 && k == kwo + hold_out) bus.audio_out_allowed = 1'b1;
      end
      bus.fx_res_valid = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      repeat (3) @(negedge CLOCK_50);
      check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'd1);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      if (!en) check({tag, "_no_fx"}, 64'(fxv_seen), 64'd0);
      exp_flag = exp_flag | tmo;
      if (tmo && exp_tocnt < 65535) exp_tocnt++;
      check({tag, "_flag"}, 64'(timeout_flag), 64'(exp_flag));
`ifdef FX_TIMEOUT_CNT_EN
      check({tag, "_tocount"}, 64'(timeout_count), 64'(exp_tocnt));
`endif
   endtask

   initial begin
      int wr0;
      bit got_it;
      bus.audio_in_available = 0;
      bus.audio_out_allowed  = 0;
      bus.left_in  = '0;
      bus.right_in = '0;
      bus.fx_ready = 0;
      bus.fx_res_valid = 0;
      bus.fx_res_L = '0;
      bus.fx_res_R = '0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_ctl", {59'd0, busy, timeout_flag, bus.read_audio_in, bus.write_audio_out, bus.fx_valid}, 64'd0);
      check("rst_out", {bus.left_out, bus.right_out}, 64'd0);
      check("rst_fx", {bus.fx_L, bus.fx_R}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge CLOCK_50);

      run_frame("byp",  1'b0, 32'h0000_1234, 32'h0000_5678, 0, -1, 32'h0, 32'h0, 0);
      run_frame("fx",   1'b1, 32'hA5A5_0001, 32'h0000_00F0, 0,  3, 32'hFFFF_0001, 32'h1234_FFFF, 0);
      run_frame("race", 1'b1, 32'h1111_2222, 32'h3333_4444, 0, TO - 1, 32'hCAFE_0001, 32'hBEEF_0002, 0);
      run_frame("bp",   1'b1, 32'h5555_AAAA, 32'h0F0F_F0F0, 5,  0, 32'h0000_0077, 32'h0000_0088, 10);
      run_frame("tmo",  1'b1, 32'h7654_3210, 32'h0123_4567, 0, -1, 32'hDEAD_DEAD, 32'hDEAD_DEAD, 0);
      for (int i = 0; i < 4; i++)
         run_frame("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 10)) - 1,
                   $urandom, $urandom, int'($urandom_range(0, 3)));

      // Reset while a bypass frame waits for DAC space: frame is dropped, no push.
      wr0 = wr_cnt;
      enable = 1'b0;
      bus.left_in  = 32'h0BAD_F00D;
      bus.right_in = 32'h0000_0099;
      bus.audio_out_allowed  = 1'b0;
      bus.audio_in_available = 1'b1;
      got_it = 0;
      for (int i = 0; i < 20 && !got_it; i++) begin
         @(negedge CLOCK_50);
         got_it = bus.read_audio_in;
      end
      check("rst_mid_read", 64'(got_it), 64'd1);
      bus.audio_in_available = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_ctl", {59'd0, busy, timeout_flag, bus.read_audio_in, bus.write_audio_out, bus.fx_valid}, 64'd0);
      check("rst_mid_out", {bus.left_out, bus.right_out}, 64'd0);
      bus.audio_out_allowed = 1'b1;
      exp_flag  = 0;
      exp_tocnt = 0;
      repeat (3) @(negedge CLOCK_50);
      reset_n = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      check("rst_mid_no_write", 64'(wr_cnt - wr0), 64'd0);
      check("rst_mid_idle", 64'(busy), 64'd0);
      run_frame("restart", 1'b0, 32'h0000_4321, 32'h0000_8765, 0, -1, 32'h0, 32'h0, 0);

      check("strobe_exclusive", 64'(excl_viol), 64'd0);
      check("strobe_single", 64'(seq_viol), 64'd0);
      check("fx_stable", 64'(stab_viol), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
